fetch_pair_queue: RTL
=====================

// Module: fetch_pair_queue
// PURPOSE
//  Dual-issue fetch front end and the requester side of the instruction ROM.
//  - Drives pc/pc_4 to the ROM; captures the two returned words (inst_1/inst_2).
//  - Buffers them with their PCs in a circular queue.
//  - Presents the two oldest entries to decode/issue; handles branch redirect and flush.
// PARAMETERS
//  RESET_PC  32'h0  PC loaded on reset
//  PC_STEP   4      address distance between consecutive instructions (pc_4 = pc + PC_STEP)
//  DEPTH     8      queue entries; power of two, >= 4
// PORTS
//  clk          in   1   clock, rising edge
//  rst          in   1   reset: synchronous, active-high
//  rom_pc       out  32  address of first word to ROM
//  rom_pc_4     out  32  rom_pc + PC_STEP to ROM
//  rom_inst_1   in   32  word at rom_pc; combinational from ROM, valid same cycle
//  rom_inst_2   in   32  word at rom_pc_4; same timing
//  redirect     in   1   branch/exception redirect; flushes queue
//  redirect_pc  in   32  new fetch PC when redirect=1
//  deq_cnt      in   2   entries consumed this cycle (0..2; 3 treated as 2)
//  out_valid    out  2   bit0: head entry valid; bit1: head+1 entry valid
//  out_inst_1   out  32  head instruction;      out_pc_1 out 32 its PC
//  out_inst_2   out  32  head+1 instruction;    out_pc_2 out 32 its PC
// BEHAVIOUR
//  - Reset: fetch_pc<=RESET_PC; head=tail=count=0; out_valid=0.
//    out_inst_*/out_pc_* are 0 while not valid.
//  - rom_pc = fetch_pc (register); rom_pc_4 = fetch_pc + PC_STEP (32-bit wrap).
//  - Enqueue condition, per cycle: !redirect && (DEPTH - count) >= 2.
//    - count is the pre-dequeue value, so no combinational path deq_cnt->enqueue.
//    - Writes {rom_pc, rom_inst_1} at tail and {rom_pc_4, rom_inst_2} at tail+1.
//    - tail += 2; fetch_pc += 2*PC_STEP.
//  - No enqueue (full, or free==1): fetch_pc holds; the ROM is re-read next cycle.
//    No partial pair is ever enqueued.
//  - Dequeue: eff = min(deq_cnt, count, 2); head += eff.
//    - deq_cnt exceeding valid entries is clipped, never underflows.
//  - count_next = count + 2*enq - eff; head and tail wrap modulo DEPTH.
//  - Outputs are combinational from registered storage at head and head+1.
//    - out_valid[0] = count>=1; out_valid[1] = count>=2. Zero-latency view of queue state.
//  - Latency: a word fetched in cycle N is visible at out_* in cycle N+1 if queue was empty.
//  - Redirect, any cycle: next cycle head=tail=count=0, fetch_pc<=redirect_pc.
//    - Same-cycle deq_cnt and ROM data are discarded.
//    - Redirect wins over enqueue and dequeue.
//    - Back-to-back redirects: the last one wins.
//  - rst overrides redirect; reset mid-stream drops all entries.
// CONFIGURATION
//  FETCH_PERF_EN defined:
//    - Adds ports perf_full_cycles (out, 32) and perf_redirects (out, 32).
//    - perf_full_cycles counts cycles with no enqueue because free<2, excluding redirect cycles.
//    - perf_redirects counts cycles with redirect=1.
//    - Both reset to 0 on rst and wrap at 2^32.
//  FETCH_PERF_EN undefined: ports and counters absent; functional behaviour identical.
// STRUCTURE
//  - Package mips_fetch_pkg: fetch_entry_t {pc[31:0], inst[31:0]}, XLEN=32, INST_W=32.
//  - Sub-module fetch_queue:
//    - Circular buffer of fetch_entry_t with 2-write/2-read ports.
//    - head/tail/count and flush input.
//  - Top holds fetch_pc, the enqueue decision and the perf counters.
// TESTING
//  1 Reset, RESET_PC=0, ROM word k = k, deq_cnt=0:
//    -> cycles 1-4 enqueue pairs; count reaches 8.
//    -> rom_pc then holds at 32 and out_inst_1/2 = 0/1.
//  2 Steady state, deq_cnt=2 every cycle from empty:
//    -> out_pc_1/out_pc_2 = 0/4, 8/12, 16/20, ...; no gaps after first fill.
//  3 Queue at count=7 with deq_cnt=1:
//    -> no enqueue (free=1); count goes 7->6.
//    -> next cycle enqueues; count 6->8-eff.
//  4 redirect=1, redirect_pc=32'h100, deq_cnt=2, queue non-empty:
//    -> next cycle out_valid=0 and rom_pc=0x100.
//    -> following cycle out_pc_1=0x100, out_pc_2=0x104.
//  5 deq_cnt=2 with count=1:
//    -> count becomes 0 + 2 (the enqueue); no underflow.
//    -> head advances exactly 1.
//  6 FETCH_PERF_EN: 4 full cycles plus 3 redirects, then rst
//    -> perf_full_cycles=4, perf_redirects=3; both read 0 after rst.

Source files
------------

// File: rtl/fetch_pair_queue_pkg.sv
// Shared types for the dual-issue fetch front end: queue entry layout and
// the dequeue clipping rule used by the fetch queue.
package mips_fetch_pkg;

  localparam int XLEN   = 32;
  localparam int INST_W = 32;

  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;

  // A request of 3 means 2; never consume more entries than are held.
  function automatic logic [1:0] deq_eff(input logic [1:0] req,
                                         input logic       have_1,
                                         input logic       have_2);
    logic [1:0] want;
    want = (req == 2'd3) ? 2'd2 : req;
    if (want == 2'd2 && !have_2) return have_1 ? 2'd1 : 2'd0;
    if (want == 2'd1 && !have_1) return 2'd0;
    return want;
  endfunction

endpackage

// File: rtl/fetch_pair_queue_if.sv
// ROM request/response and decode-side view of the fetch pair queue.
// master = fetch unit, slave = ROM plus decode/issue environment.
interface fetch_pair_queue_if;
  import mips_fetch_pkg::*;

  logic [XLEN-1:0]   rom_pc;
  logic [XLEN-1:0]   rom_pc_4;
  logic [INST_W-1:0] rom_inst_1;
  logic [INST_W-1:0] rom_inst_2;
  logic              redirect;
  logic [XLEN-1:0]   redirect_pc;
  logic [1:0]        deq_cnt;
  logic [1:0]        out_valid;
  logic [INST_W-1:0] out_inst_1;
  logic [XLEN-1:0]   out_pc_1;
  logic [INST_W-1:0] out_inst_2;
  logic [XLEN-1:0]   out_pc_2;

  modport master (
    output rom_pc, rom_pc_4, out_valid, out_inst_1, out_pc_1, out_inst_2, out_pc_2,
    input  rom_inst_1, rom_inst_2, redirect, redirect_pc, deq_cnt
  );

  modport slave (
    input  rom_pc, rom_pc_4, out_valid, out_inst_1, out_pc_1, out_inst_2, out_pc_2,
    output rom_inst_1, rom_inst_2, redirect, redirect_pc, deq_cnt
  );

endinterface

// File: rtl/fetch_pair_queue_fetch_queue.sv
// Circular buffer of fetch entries with two write ports (always used as a
// pair) and two read ports at head/head+1; flush empties it in one cycle.
module fetch_queue
  import mips_fetch_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   enq,
  input  fetch_entry_t           wr_0,
  input  fetch_entry_t           wr_1,
  input  logic [1:0]             deq_cnt,
  output logic [$clog2(DEPTH):0] count,
  output fetch_entry_t           rd_0,
  output fetch_entry_t           rd_1,
  output logic [1:0]             rd_valid
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [AW-1:0] head_1;
  logic [AW-1:0] tail_1;
  logic [1:0]    eff;
  logic          do_enq;
  logic [CW-1:0] enq_add;

  assign head_1   = head + AW'(1);
  assign tail_1   = tail + AW'(1);
  assign rd_valid = {count >= CW'(2), count != '0};
  assign eff      = deq_eff(deq_cnt, rd_valid[0], rd_valid[1]);
  assign do_enq   = enq && !flush;
  assign enq_add  = do_enq ? CW'(2) : '0;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + AW'(eff);
      tail  <= tail + AW'(enq_add);
      count <= count + enq_add - CW'(eff);
    end
  end

  // Storage carries no reset; stale slots are hidden by the valid gating below.
  always_ff @(posedge clk) begin
    if (do_enq && !rst) begin
      mem[tail]   <= wr_0;
      mem[tail_1] <= wr_1;
    end
  end

  always_comb begin
    rd_0 = '0;
    rd_1 = '0;
    if (rd_valid[0]) rd_0 = mem[head];
    if (rd_valid[1]) rd_1 = mem[head_1];
  end

endmodule

// File: rtl/fetch_pair_queue.sv
// Dual-issue fetch front end: fetch PC, pair enqueue decision, redirect.
// Optional FETCH_PERF_EN adds full-stall and redirect event counters.
module fetch_pair_queue
  import mips_fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0,
  parameter int unsigned     PC_STEP  = 4,
  parameter int              DEPTH    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  fetch_pair_queue_if.master   bus
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]          perf_full_cycles,
  output logic [31:0]          perf_redirects
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [XLEN-1:0] STEP = XLEN'(PC_STEP);

  logic [XLEN-1:0] fetch_pc;
  logic [CW-1:0]   count;
  logic            has_room;
  logic            enq;
  fetch_entry_t    wr_0;
  fetch_entry_t    wr_1;
  fetch_entry_t    rd_0;
  fetch_entry_t    rd_1;
  logic [1:0]      rd_valid;

  // Room is judged on the pre-dequeue count so deq_cnt never reaches enqueue.
  assign has_room = count <= CW'(DEPTH - 2);
  assign enq      = !bus.redirect && has_room;

  assign bus.rom_pc   = fetch_pc;
  assign bus.rom_pc_4 = fetch_pc + STEP;

  assign wr_0 = '{pc: bus.rom_pc,   inst: bus.rom_inst_1};
  assign wr_1 = '{pc: bus.rom_pc_4, inst: bus.rom_inst_2};

  always_ff @(posedge clk) begin
    if (rst)               fetch_pc <= RESET_PC;
    else if (bus.redirect) fetch_pc <= bus.redirect_pc;
    else if (enq)          fetch_pc <= fetch_pc + (STEP << 1);
  end

  fetch_queue #(
    .DEPTH (DEPTH)
  ) u_queue (
    .clk      (clk),
    .rst      (rst),
    .flush    (bus.redirect),
    .enq      (enq),
    .wr_0     (wr_0),
    .wr_1     (wr_1),
    .deq_cnt  (bus.deq_cnt),
    .count    (count),
    .rd_0     (rd_0),
    .rd_1     (rd_1),
    .rd_valid (rd_valid)
  );

  assign bus.out_valid  = rd_valid;
  assign bus.out_inst_1 = rd_0.inst;
  assign bus.out_pc_1   = rd_0.pc;
  assign bus.out_inst_2 = rd_1.inst;
  assign bus.out_pc_2   = rd_1.pc;

`ifdef FETCH_PERF_EN
  // A redirect cycle never counts as a full stall even if the queue was full.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_full_cycles <= '0;
      perf_redirects   <= '0;
    end else begin
      if (!bus.redirect && !has_room) perf_full_cycles <= perf_full_cycles + 32'd1;
      if (bus.redirect)               perf_redirects   <= perf_redirects + 32'd1;
    end
  end
`endif

endmodule
